// File: rtl/fwd_scoreboard.sv
// Forwarding and interlock scoreboard: tracks in-flight register writes per post-decode stage
// and resolves per-port operand forwarding or a stall on the youngest not-yet-ready producer.
module fwd_scoreboard #(
    parameter int NRP  = 2,
    parameter int NST  = 3,
    parameter int LATW = 3,
    parameter int RW   = 5,
    parameter int DW   = 32,
    localparam int SW  = $clog2(NST + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              issue_valid,
    input  logic              issue_wen,
    input  logic [RW-1:0]     issue_dest,
    input  logic [LATW-1:0]   issue_lat,
    input  logic              advance,
    input  logic [NST-1:0]    flush_mask,
    input  logic [NRP*RW-1:0] rd_addr,
    input  logic [NRP*DW-1:0] rf_data,
    input  logic [NST*DW-1:0] stage_data,
    output logic [NRP*SW-1:0] fwd_sel,
    output logic [NRP*DW-1:0] fwd_data,
    output logic              stall,
    output logic [NST-1:0]    occ
);

    // Countdown step that holds at zero; also maps an issue latency of 0 onto 1.
    function automatic logic [LATW-1:0] sat_dec(input logic [LATW-1:0] c);
        return (c == {LATW{1'b0}}) ? {LATW{1'b0}} : c - LATW'(1);
    endfunction

    logic [NST-1:0]  valid_r;
    logic [NST-1:0]  wen_r;
    logic [RW-1:0]   dest_r [NST];
    logic [LATW-1:0] cnt_r  [NST];

    logic [NST-1:0]  live_s;
    logic [NRP-1:0]  hit_s;
    logic [NRP-1:0]  rdy_s;
    logic [NRP-1:0]  blocked_s;
    logic [SW-1:0]   hit_sel_s  [NRP];
    logic [DW-1:0]   hit_data_s [NRP];

    assign live_s = valid_r & ~flush_mask;
    assign stall  = |blocked_s;
    assign occ    = valid_r;

    // Per-port search, oldest to youngest so the youngest matching entry wins.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            hit_s[p]      = 1'b0;
            rdy_s[p]      = 1'b0;
            hit_sel_s[p]  = {SW{1'b0}};
            hit_data_s[p] = {DW{1'b0}};
            for (int k = NST - 1; k >= 0; k--) begin
                if (valid_r[k] && wen_r[k] && (dest_r[k] == rd_addr[p*RW +: RW]) &&
                    (rd_addr[p*RW +: RW] != {RW{1'b0}})) begin
                    hit_s[p]      = 1'b1;
                    rdy_s[p]      = (cnt_r[k] == {LATW{1'b0}});
                    hit_sel_s[p]  = SW'(k + 1);
                    hit_data_s[p] = stage_data[k*DW +: DW];
                end else begin
                    hit_s[p] = hit_s[p];
                end
            end
        end
    end

    // Operand select per port; a not-ready youngest producer blocks with no fallback.
    always_comb begin
        fwd_sel   = {(NRP*SW){1'b0}};
        fwd_data  = rf_data;
        blocked_s = {NRP{1'b0}};
        for (int p = 0; p < NRP; p++) begin
            if (hit_s[p] && rdy_s[p]) begin
                fwd_sel[p*SW +: SW]  = hit_sel_s[p];
                fwd_data[p*DW +: DW] = hit_data_s[p];
            end else if (hit_s[p]) begin
                blocked_s[p] = 1'b1;
            end else begin
                fwd_sel[p*SW +: SW] = {SW{1'b0}};
            end
        end
    end

    // Scoreboard shift register: flush first, then shift/issue when the pipeline advances.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r <= {NST{1'b0}};
            wen_r   <= {NST{1'b0}};
            for (int k = 0; k < NST; k++) begin
                dest_r[k] <= {RW{1'b0}};
                cnt_r[k]  <= {LATW{1'b0}};
            end
        end else if (advance) begin
            valid_r[0] <= issue_valid & ~stall;
            wen_r[0]   <= issue_wen;
            dest_r[0]  <= issue_dest;
            cnt_r[0]   <= sat_dec(issue_lat);
            for (int k = 1; k < NST; k++) begin
                valid_r[k] <= live_s[k-1];
                wen_r[k]   <= wen_r[k-1];
                dest_r[k]  <= dest_r[k-1];
                cnt_r[k]   <= sat_dec(cnt_r[k-1]);
            end
        end else begin
            valid_r <= live_s;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a pipeline-level reference model.
module tb_fwd_scoreboard;

    localparam int NRP = 2, NST = 3, LATW = 3, RW = 5, DW = 32, SW = 2;

    logic              CLK;
    logic              nRST;
    logic              issue_valid;
    logic              issue_wen;
    logic [RW-1:0]     issue_dest;
    logic [LATW-1:0]   issue_lat;
    logic              advance;
    logic [NST-1:0]    flush_mask;
    logic [NRP*RW-1:0] rd_addr;
    logic [NRP*DW-1:0] rf_data;
    logic [NST*DW-1:0] stage_data;
    logic [NRP*SW-1:0] fwd_sel;
    logic [NRP*DW-1:0] fwd_data;
    logic              stall;
    logic [NST-1:0]    occ;

    fwd_scoreboard #(.NRP(NRP), .NST(NST), .LATW(LATW), .RW(RW), .DW(DW)) dut (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_dest(issue_dest), .issue_lat(issue_lat), .advance(advance),
        .flush_mask(flush_mask), .rd_addr(rd_addr), .rf_data(rf_data),
        .stage_data(stage_data), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .stall(stall), .occ(occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: one record per in-flight instruction, index 0 = youngest (EX).
    bit          m_v [NST];
    bit          m_w [NST];
    int          m_d [NST];
    int          m_c [NST];
    int          e_sel  [NRP];
    logic [31:0] e_data [NRP];
    bit          e_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NST; k++) begin
            m_v[k] = 1'b0; m_w[k] = 1'b0; m_d[k] = 0; m_c[k] = 0;
        end
    endtask

    task automatic compute_exp();
        int a;
        if (!nRST) model_clear();
        e_stall = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            e_sel[p]  = 0;
            e_data[p] = rf_data[p*DW +: DW];
            a = int'(rd_addr[p*RW +: RW]);
            if (a != 0) begin
                for (int k = 0; k < NST; k++) begin
                    if (m_v[k] && m_w[k] && m_d[k] == a) begin
                        if (m_c[k] == 0) begin
                            e_sel[p]  = k + 1;
                            e_data[p] = stage_data[k*DW +: DW];
                        end else begin
                            e_stall = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("occ", 64'(occ), 64'({m_v[2], m_v[1], m_v[0]}));
        chk("stall", 64'(stall), 64'(e_stall));
        for (int p = 0; p < NRP; p++) begin
            chk($sformatf("fwd_sel%0d", p), 64'(fwd_sel[p*SW +: SW]), 64'(e_sel[p]));
            chk($sformatf("fwd_data%0d", p), 64'(fwd_data[p*DW +: DW]), 64'(e_data[p]));
        end
    endtask

    task automatic model_clock();
        if (!nRST) begin
            model_clear();
        end else begin
            for (int k = 0; k < NST; k++) if (flush_mask[k]) m_v[k] = 1'b0;
            if (advance) begin
                for (int k = NST - 1; k >= 1; k--) begin
                    m_v[k] = m_v[k-1];
                    m_w[k] = m_w[k-1];
                    m_d[k] = m_d[k-1];
                    m_c[k] = (m_c[k-1] > 0) ? m_c[k-1] - 1 : 0;
                end
                m_v[0] = issue_valid && !e_stall;
                m_w[0] = issue_wen;
                m_d[0] = int'(issue_dest);
                m_c[0] = (issue_lat > 0) ? int'(issue_lat) - 1 : 0;
            end
        end
    endtask

    // Inputs must already be stable; compare, step the model, cross the clock edge.
    task automatic cyc();
        compute_exp();
        cmp_model();
        model_clock();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        #1;
        cyc();
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_dest = 5'd0; issue_lat = 3'd0;
        advance = 1'b1; flush_mask = 3'b000; rd_addr = 10'd0;
        rf_data = {$urandom(), $urandom()};
        stage_data = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic issue(input int dest, input int lat);
        set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1;
        issue_dest = RW'(dest); issue_lat = LATW'(lat);
        tick();
    endtask

    task automatic drain();
        set_idle();
        repeat (3) tick();
    endtask

    initial begin
        nRST = 1'b0;
        model_clear();
        set_idle();
        // Reset with stale issue traffic
        issue_valid = 1'b1; issue_wen = 1'b1; issue_dest = 5'd3; issue_lat = 3'd1;
        rd_addr = {5'd3, 5'd3};
        @(posedge CLK); #1;
        #1;
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_sel", 64'(fwd_sel), 64'd0);
        chk("rst_data", 64'(fwd_data), 64'(rf_data));
        cyc();
        cyc();
        nRST = 1'b1;

        // ALU chain
        drain();
        issue(8, 1);
        set_idle();
        rd_addr[4:0] = 5'd8;
        stage_data[31:0] = 32'h0000_1234;
        #1;
        chk("alu_sel_ex", 64'(fwd_sel[1:0]), 64'd1);
        chk("alu_data_ex", 64'(fwd_data[31:0]), 64'h1234);
        chk("alu_stall", 64'(stall), 64'd0);
        cyc();
        tick();
        #1;
        chk("alu_sel_wb", 64'(fwd_sel[1:0]), 64'd3);
        chk("alu_data_wb", 64'(fwd_data[31:0]), 64'(stage_data[95:64]));
        cyc();
        #1;
        chk("alu_sel_retired", 64'(fwd_sel[1:0]), 64'd0);
        cyc();

        // Load-use interlock held through a memory wait
        drain();
        issue(9, 2);
        set_idle();
        rd_addr[9:5] = 5'd9;
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_stall_hold", 64'(stall), 64'd1);
            chk("ld_sel_hold", 64'(fwd_sel[3:2]), 64'd0);
            cyc();
        end
        advance = 1'b1;
        tick();
        #1;
        chk("ld_sel_mem", 64'(fwd_sel[3:2]), 64'd2);
        chk("ld_stall_clear", 64'(stall), 64'd0);
        cyc();

        // Youngest producer wins even if not ready
        drain();
        issue(10, 1);
        issue(10, 2);
        set_idle();
        rd_addr[4:0] = 5'd10;
        #1;
        chk("young_stall", 64'(stall), 64'd1);
        chk("young_sel", 64'(fwd_sel[1:0]), 64'd0);
        cyc();
        #1;
        chk("young_sel_next", 64'(fwd_sel[1:0]), 64'd2);
        cyc();

        // Register 0 never forwards
        drain();
        issue(0, 1);
        set_idle();
        #1;
        chk("r0_sel", 64'(fwd_sel[1:0]), 64'd0);
        chk("r0_stall", 64'(stall), 64'd0);
        cyc();

        // Flush of EX while frozen exposes the older producer
        drain();
        issue(5, 1);
        issue(5, 1);
        set_idle();
        rd_addr[4:0] = 5'd5;
        flush_mask = 3'b001;
        advance = 1'b0;
        tick();
        flush_mask = 3'b000;
        #1;
        chk("flush_sel", 64'(fwd_sel[1:0]), 64'd2);
        chk("flush_occ", 64'(occ), 64'b010);
        cyc();

        // Asynchronous reset mid-cycle
        drain();
        issue(6, 7);
        issue(6, 7);
        issue(6, 7);
        set_idle();
        rd_addr[4:0] = 5'd6;
        advance = 1'b0;
        #1;
        chk("arst_pre_occ", 64'(occ), 64'b111);
        chk("arst_pre_stall", 64'(stall), 64'd1);
        nRST = 1'b0;
        #1;
        chk("arst_occ", 64'(occ), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        cyc();
        nRST = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            nRST        = ($urandom_range(0, 299) != 0);
            issue_valid = $urandom_range(0, 3) != 0;
            issue_wen   = $urandom_range(0, 4) != 0;
            issue_dest  = RW'($urandom_range(0, 7));
            issue_lat   = LATW'($urandom_range(0, 7));
            advance     = $urandom_range(0, 3) != 0;
            flush_mask  = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                           $urandom_range(0, 7) == 0};
            rd_addr     = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            rf_data     = {$urandom(), $urandom()};
            stage_data  = {$urandom(), $urandom(), $urandom()};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and interlock unit for the pipelined datapath; successor to the fixed EX/MEM/WB forwarding logic.
- Keeps a registered scoreboard of in-flight register writes, one entry per post-decode stage, each with a variable-latency countdown (ALU = 1, load = 2, multi-cycle ops > 2).
- For NRP decode read ports it returns the forwarding select and forwarded data, or raises stall when the youngest producer is not ready.
- Sits between decode and the pipeline latches; the hazard unit consumes stall.

Parameters:
- NRP, 2: number of decode read ports.
- NST, 3: tracked stages after decode. Entry 0 = EX, entry NST-1 = WB.
- LATW, 3: width of the latency counter.
- RW, 5: register address width.
- DW, 32: data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction leaves decode this cycle.
- issue_wen  in  1  instruction writes the register file.
- issue_dest  in  RW  destination register.
- issue_lat  in  LATW  stage advances until result exists; 1..2^LATW-1.
- advance  in  1  pipeline latches advance (0 = memory wait freeze).
- flush_mask  in  NST  per-entry squash, applied at the clock edge.
- rd_addr  in  NRP*RW  source register of each read port; port p = bits [p*RW +: RW].
- rf_data  in  NRP*DW  register file read data per port.
- stage_data  in  NST*DW  result value of the instruction in entry k.
- fwd_sel  out  NRP*SW  per port: 0 = register file, k+1 = entry k. SW = $clog2(NST+1).
- fwd_data  out  NRP*DW  selected operand per port.
- stall  out  1  some port needs a value that is not yet produced.
- occ  out  NST  entry valid bits.

Behaviour:
- Entry state: valid, wen, dest[RW], cnt[LATW].
- Reset (asynchronous, nRST=0): all entries valid=0, wen=0, dest=0, cnt=0. Therefore fwd_sel=0, fwd_data=rf_data, stall=0, occ=0.
- Per-port match for entry k: valid && wen && dest==rd_addr[p] && rd_addr[p]!=0. Register 0 never forwards and never stalls.
- Port resolution:
  - Select the youngest matching entry (lowest k). Older matches are ignored.
  - If that entry has cnt==0: fwd_sel = k+1, fwd_data = stage_data[k].
  - If it has cnt!=0: port is blocked; fwd_sel = 0, fwd_data = rf_data. Do not fall back to older entries.
  - If nothing matches: fwd_sel = 0, fwd_data = rf_data.
- stall = OR of blocked ports. All outputs are combinational from registered state and current inputs; zero cycle latency.
- Clock edge with advance=1:
  - entry[k+1] <= entry[k], with cnt decremented and saturating at 0.
  - Entry NST-1 retires; the register file holds its value from then on.
  - entry[0] <= {valid = issue_valid && !stall, wen = issue_wen, dest = issue_dest, cnt = issue_lat-1}.
  - If issue_valid && !stall is false, entry[0] becomes a bubble (valid=0).
- Clock edge with advance=0: no shift, no decrement, no issue. Stall persists unchanged.
- flush_mask[k]=1 clears valid of entry k before the shift. A flushed entry moves on as a bubble. Flush applies whether advance is 0 or 1.
- Simultaneous events:
  - Flush of entry 0 together with a new issue: the new issue is kept.
  - Issue with issue_lat=0 is treated as 1 (cnt loads 0).
- nRST deasserted mid-operation empties the scoreboard immediately. Any in-flight hazard is lost by design; the core is reset together.

Test Plan (NST=3, NRP=2):
- Reset: hold nRST=0 with stale issues and advance=1 -> occ=000, stall=0, fwd_sel=0/0, fwd_data=rf_data.
- ALU chain: issue dest=8 lat=1, advance. Next cycle rd_addr0=8, stage_data[0]=0x1234 -> fwd_sel0=1, fwd_data0=0x1234, stall=0. After two more advances -> fwd_sel0=3. One further advance -> fwd_sel0=0.
- Load-use: issue dest=9 lat=2, advance. rd_addr1=9 -> stall=1, fwd_sel1=0. Hold advance=0 for 3 cycles -> stall stays 1. One advance -> fwd_sel1=2, stall=0.
- Youngest wins: issue dest=10 (lat 1) then dest=10 again (lat 2). rd_addr0=10 -> stall=1; the older ready entry is not used. Next advance -> fwd_sel0=2.
- Register 0 and flush: entry0 has dest=0 and rd_addr0=0 -> fwd_sel0=0, stall=0. With entries 0 and 1 both dest=5, assert flush_mask=001, advance=0, rd_addr0=5 -> next cycle fwd_sel0=2.
- Async reset mid-op: occ=111 with stall=1, pulse nRST low mid-cycle -> occ=000 and stall=0 immediately, without waiting for CLK.
